// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and state encoding for the fetch unit
//
// Purpose: reset PC, NOP encoding and the 2-bit fetch state encoding used by
//          fetch_unit and by any bench that needs to interpret its state.
// Ports:   none (package).

package fetch_unit_pkg;

  // PC value after reset; also the reset value of inst_pc.
  localparam logic [31:0] FU_RESET_PC = 32'h0000_2000;

  // addi x0,x0,0 -- presented to decode while nothing valid is held.
  localparam logic [31:0] FU_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_ISSUE   = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DELIVER = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - blocking instruction fetch between the PC and decode
//
// Purpose: fetches the instruction at pc over the I-cache CPU interface with at
//          most one request in flight, holds it for decode, drives the PC stall
//          and discards fetches made stale by a redirect.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   pc                               current PC from the PC register
//   redirect                         PC loads a branch/jump target at next edge
//   dec_stall                        decode cannot accept an instruction
//   fetch_stall                      PC stall (0 = PC updates at next edge)
//   inst, inst_pc, inst_valid        instruction, its address, and valid flag
//   cpu_req_valid/ready/addr/data/write   I-cache request channel
//   cpu_resp_valid/data              I-cache response (one-cycle pulse)

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FU_RESET_PC,
  parameter logic [31:0] NOP      = FU_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic        dec_stall,
  output logic        fetch_stall,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        cpu_req_valid,
  input  logic        cpu_req_ready,
  output logic [29:0] cpu_req_addr,
  output logic [31:0] cpu_req_data,
  output logic [3:0]  cpu_req_write,
  input  logic        cpu_resp_valid,
  input  logic [31:0] cpu_resp_data
);

  fetch_state_e state_q, state_d;
  logic         squash_q, squash_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  req_pc_q, req_pc_d;

  logic         handshake;
  logic         deliver_release;

  // Byte offset within the word is not used for fetch.
  logic         unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

  always_comb begin
    state_d      = state_q;
    squash_d     = squash_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    req_pc_d     = req_pc_q;

    cpu_req_valid = !reset && (state_q == FETCH_ISSUE);
    cpu_req_addr  = pc[31:2];
    cpu_req_data  = 32'h0;
    cpu_req_write = 4'h0;

    handshake       = cpu_req_valid && cpu_req_ready;
    deliver_release = (state_q == FETCH_DELIVER) && (redirect || !dec_stall);

    // The PC moves only when decode takes the held instruction, or when it
    // must load a redirect target; every other cycle it is frozen.
    fetch_stall = reset || !(redirect || ((state_q == FETCH_DELIVER) && !dec_stall));

    inst       = inst_q;
    inst_pc    = inst_pc_q;
    inst_valid = inst_valid_q;

    unique case (state_q)
      FETCH_ISSUE: begin
        if (handshake) begin
          req_pc_d = pc;
          state_d  = FETCH_WAIT;
          // Request went out with the old pc while the PC is loading a new
          // target: the returning data belongs to the wrong path.
          squash_d = redirect;
        end
      end

      FETCH_WAIT: begin
        if (cpu_resp_valid) begin
          squash_d = 1'b0;
          if (squash_q || redirect) begin
            state_d = FETCH_ISSUE;
          end else begin
            inst_d       = cpu_resp_data;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            state_d      = FETCH_DELIVER;
          end
        end else if (redirect) begin
          squash_d = 1'b1;
        end
      end

      FETCH_DELIVER: begin
        // Redirect dominates dec_stall: the held instruction is on the wrong
        // path and is discarded. inst_pc keeps its last value.
        if (deliver_release) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP;
          state_d      = FETCH_ISSUE;
        end
      end

      default: begin
        state_d = FETCH_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_ISSUE;
      squash_q     <= 1'b0;
      inst_q       <= NOP;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      req_pc_q     <= RESET_PC;
    end else begin
      state_q      <= state_d;
      squash_q     <= squash_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      req_pc_q     <= req_pc_d;
    end
  end

endmodule
